de1_blinker_nios2_proc_oci_dct_ctrl: RTL and testbench

DE1_BLINKER_NIOS2_PROC_OCI_DCT_CTRL -- requirements
Module: de1_blinker_nios2_proc_oci_dct_ctrl

---
 rtl/de1_blinker_nios2_proc_oci_dct_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_de1_blinker_nios2_proc_oci_dct_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/de1_blinker_nios2_proc_oci_dct_ctrl.sv
// Debug trace capture controller: records DCT frames into a circular store
// while armed, keeps a programmable number of frames after the stop trigger,
// then dumps the store oldest-first over a valid/ready read port.
module de1_blinker_nios2_proc_oci_dct_ctrl #(
    parameter int DEPTH_LOG2 = 4,
    parameter int POST_COUNT = 4,
    parameter bit WRAP_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  stop,
    input  logic                  dct_valid,
    input  logic [29:0]           dct_buffer,
    input  logic [3:0]            dct_count,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [33:0]           rd_data,
    output logic [1:0]            state,
    output logic [DEPTH_LOG2:0]   entries,
    output logic                  wrapped,
    output logic                  dump_done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] FULL_M1    = (DEPTH_LOG2+1)'(DEPTH - 1);
    localparam logic [DEPTH_LOG2:0] ONE_CNT    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] ZERO_CNT   = '0;
    localparam logic [8:0]          POST_LIMIT = 9'(POST_COUNT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [33:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_reg;
    logic [DEPTH_LOG2-1:0]   rd_ptr_reg;
    logic [DEPTH_LOG2:0]     entries_reg;
    logic [DEPTH_LOG2:0]     rd_remaining_reg;
    logic [7:0]              post_cnt_reg;
    logic                    wrapped_reg;
    logic                    dump_active_reg;
    logic                    rd_valid_reg;
    logic [33:0]             rd_data_reg;
    logic                    dump_done_reg;

    logic                    capturing;
    logic                    store_full;
    logic                    write_en;
    logic                    fill_done;
    logic                    post_done;
    logic                    xfer;
    logic                    last_xfer;
    logic                    empty_done;
    logic [DEPTH_LOG2-1:0]   start_ptr;

    // Decode write, completion and handshake conditions from current state
    always_comb begin
        capturing  = (state_reg == S_CAPTURE) || (state_reg == S_POST);
        store_full = (entries_reg == DEPTH_CNT);
        // With wrapping disabled a full store never accepts another frame
        write_en   = capturing && dct_valid && !(store_full && !WRAP_EN);
        fill_done  = !WRAP_EN && write_en && (entries_reg == FULL_M1);
        post_done  = (state_reg == S_POST) && write_en &&
                     (({1'b0, post_cnt_reg} + 9'd1) == POST_LIMIT);
        xfer       = rd_valid_reg && rd_ready;
        last_xfer  = xfer && (rd_remaining_reg == ONE_CNT);
        empty_done = (state_reg == S_DONE) && !dump_active_reg &&
                     (entries_reg == ZERO_CNT);
        // Oldest frame sits at the write pointer once the store has wrapped
        start_ptr  = wrapped_reg ? wr_ptr_reg : '0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (arm) state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (fill_done) begin
                    state_next = S_DONE;
                end else if (stop) begin
                    state_next = (POST_COUNT == 0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (fill_done || post_done) state_next = S_DONE;
            end
            S_DONE: begin
                if (last_xfer || empty_done) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Trace store write port; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr_reg] <= {dct_count, dct_buffer};
        end
    end

    // Capture bookkeeping and the registered dump read path
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            entries_reg      <= '0;
            rd_remaining_reg <= '0;
            post_cnt_reg     <= '0;
            wrapped_reg      <= 1'b0;
            dump_active_reg  <= 1'b0;
            rd_valid_reg     <= 1'b0;
            rd_data_reg      <= '0;
            dump_done_reg    <= 1'b0;
        end else begin
            dump_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (arm) begin
                        wr_ptr_reg      <= '0;
                        entries_reg     <= '0;
                        wrapped_reg     <= 1'b0;
                        post_cnt_reg    <= '0;
                        dump_active_reg <= 1'b0;
                    end
                end
                S_CAPTURE, S_POST: begin
                    if (write_en) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        if (store_full) begin
                            wrapped_reg <= 1'b1;
                        end else begin
                            entries_reg <= entries_reg + ONE_CNT;
                        end
                        // The frame riding on the stop pulse is still CAPTURE
                        if (state_reg == S_POST) begin
                            post_cnt_reg <= post_cnt_reg + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (!dump_active_reg) begin
                        // First DONE cycle: set up the dump from final counters
                        rd_remaining_reg <= entries_reg;
                        if (entries_reg == ZERO_CNT) begin
                            dump_done_reg <= 1'b1;
                        end else begin
                            dump_active_reg <= 1'b1;
                            rd_data_reg     <= mem[start_ptr];
                            rd_ptr_reg      <= start_ptr + 1'b1;
                            rd_valid_reg    <= 1'b1;
                        end
                    end else if (xfer) begin
                        rd_remaining_reg <= rd_remaining_reg - ONE_CNT;
                        if (rd_remaining_reg == ONE_CNT) begin
                            rd_valid_reg    <= 1'b0;
                            dump_done_reg   <= 1'b1;
                            dump_active_reg <= 1'b0;
                        end else begin
                            rd_data_reg <= mem[rd_ptr_reg];
                            rd_ptr_reg  <= rd_ptr_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rd_data_reg;
    assign state     = state_reg;
    assign entries   = entries_reg;
    assign wrapped   = wrapped_reg;
    assign dump_done = dump_done_reg;

endmodule

// File: tb/tb_de1_blinker_nios2_proc_oci_dct_ctrl.sv
// Directed bench for the trace capture controller. Three instances cover the
// default, no-wrap (depth 4) and POST_COUNT=0 configurations; a reference
// queue of expected dump frames is filled as frames are driven and drained
// as the DUT hands frames out.
module tb_de1_blinker_nios2_proc_oci_dct_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        arm_s   [3];
    logic        stop_s  [3];
    logic        val_s   [3];
    logic        ready_s [3];
    logic [29:0] buf_s   [3];
    logic [3:0]  cnt_s   [3];
    logic        rdv_w   [3];
    logic [33:0] rdd_w   [3];
    logic [1:0]  st_w    [3];
    logic        wr_w    [3];
    logic        dd_w    [3];
    logic [4:0]  ent0, ent2;
    logic [2:0]  ent1;

    int errors = 0;
    int checks = 0;
    int sel = 0;

    // Reference model of what the store should hold
    logic [33:0] exp_q [$];
    bit m_active, m_post, m_wrapped, m_wrap_en;
    int m_pc, m_limit, m_depth;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    de1_blinker_nios2_proc_oci_dct_ctrl u_def (
        .clk(clk), .reset_n(reset_n), .arm(arm_s[0]), .stop(stop_s[0]),
        .dct_valid(val_s[0]), .dct_buffer(buf_s[0]), .dct_count(cnt_s[0]),
        .rd_ready(ready_s[0]), .rd_valid(rdv_w[0]), .rd_data(rdd_w[0]),
        .state(st_w[0]), .entries(ent0), .wrapped(wr_w[0]), .dump_done(dd_w[0]));

    de1_blinker_nios2_proc_oci_dct_ctrl #(.DEPTH_LOG2(2), .WRAP_EN(1'b0)) u_nw (
        .clk(clk), .reset_n(reset_n), .arm(arm_s[1]), .stop(stop_s[1]),
        .dct_valid(val_s[1]), .dct_buffer(buf_s[1]), .dct_count(cnt_s[1]),
        .rd_ready(ready_s[1]), .rd_valid(rdv_w[1]), .rd_data(rdd_w[1]),
        .state(st_w[1]), .entries(ent1), .wrapped(wr_w[1]), .dump_done(dd_w[1]));

    de1_blinker_nios2_proc_oci_dct_ctrl #(.POST_COUNT(0)) u_p0 (
        .clk(clk), .reset_n(reset_n), .arm(arm_s[2]), .stop(stop_s[2]),
        .dct_valid(val_s[2]), .dct_buffer(buf_s[2]), .dct_count(cnt_s[2]),
        .rd_ready(ready_s[2]), .rd_valid(rdv_w[2]), .rd_data(rdd_w[2]),
        .state(st_w[2]), .entries(ent2), .wrapped(wr_w[2]), .dump_done(dd_w[2]));

    function automatic logic [4:0] ent_sel();
        if (sel == 1) return {2'b00, ent1};
        if (sel == 2) return ent2;
        return ent0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic use_inst(input int s);
        sel       = s;
        m_depth   = (s == 1) ? 4 : 16;
        m_wrap_en = (s != 1);
        m_limit   = (s == 2) ? 0 : 4;
    endtask

    task automatic model_frame(input logic [33:0] f);
        if (m_active) begin
            exp_q.push_back(f);
            if (exp_q.size() > m_depth) begin
                void'(exp_q.pop_front());
                m_wrapped = 1'b1;
            end
            if (!m_wrap_en && exp_q.size() == m_depth) m_active = 1'b0;
            if (m_post) begin
                m_pc++;
                if (m_pc == m_limit) m_active = 1'b0;
            end
        end
    endtask

    task automatic model_stop();
        if (m_active && !m_post) begin
            m_post = 1'b1;
            if (m_limit == 0) m_active = 1'b0;
        end
    endtask

    task automatic do_arm();
        exp_q.delete();
        m_active = 1'b1; m_post = 1'b0; m_pc = 0; m_wrapped = 1'b0;
        arm_s[sel] = 1'b1;
        tick();
        arm_s[sel] = 1'b0;
    endtask

    task automatic send(input logic [29:0] b, input logic [3:0] c, input bit with_stop);
        val_s[sel] = 1'b1; buf_s[sel] = b; cnt_s[sel] = c; stop_s[sel] = with_stop;
        model_frame({c, b});
        if (with_stop) model_stop();
        tick();
        val_s[sel] = 1'b0; stop_s[sel] = 1'b0;
    endtask

    task automatic do_stop();
        stop_s[sel] = 1'b1;
        model_stop();
        tick();
        stop_s[sel] = 1'b0;
    endtask

    // Drain the dump, optionally with the 1,0,0,1 ready pattern
    task automatic dump(input bit backpressure);
        int guard = 0;
        int k = 0;
        logic [33:0] held;
        logic [33:0] want;
        bit r;
        while (!rdv_w[sel] && guard < 20) begin tick(); guard++; end
        check("rd_valid_rise", 64'(rdv_w[sel]), 64'd1);
        while (exp_q.size() > 0 && guard < 400) begin
            r = backpressure ? pat[k % 4] : 1'b1;
            k++;
            ready_s[sel] = r;
            held = rdd_w[sel];
            if (r) begin
                want = exp_q.pop_front();
                check("rd_valid", 64'(rdv_w[sel]), 64'd1);
                check("rd_data", 64'(rdd_w[sel]), 64'(want));
                check("no_early_done", 64'(dd_w[sel]), 64'd0);
                $display("xfer inst=%0d data=%09h", sel, rdd_w[sel]);
            end
            tick();
            guard++;
            if (!r) begin
                check("hold_data", 64'(rdd_w[sel]), 64'(held));
                check("hold_valid", 64'(rdv_w[sel]), 64'd1);
            end
        end
        ready_s[sel] = 1'b0;
        check("dump_in_time", 64'(guard < 400), 64'd1);
        check("dump_done_pulse", 64'(dd_w[sel]), 64'd1);
        check("rd_valid_low", 64'(rdv_w[sel]), 64'd0);
        check("idle_after_dump", 64'(st_w[sel]), 64'd0);
        tick();
        check("dump_done_single", 64'(dd_w[sel]), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            arm_s[i] = 0; stop_s[i] = 0; val_s[i] = 0; ready_s[i] = 0;
            buf_s[i] = '0; cnt_s[i] = '0;
        end
        use_inst(0);
        tick(); tick();
        check("reset_state", 64'(st_w[0]), 64'd0);
        check("reset_entries", 64'(ent0), 64'd0);
        check("reset_wrapped", 64'(wr_w[0]), 64'd0);
        check("reset_rd_valid", 64'(rdv_w[0]), 64'd0);
        check("reset_rd_data", 64'(rdd_w[0]), 64'd0);
        reset_n = 1'b1;

        // Defaults: 3 pre-trigger frames, stop, 4 post frames (arm on first live cycle)
        do_arm();
        check("armed_capture", 64'(st_w[0]), 64'd1);
        for (int i = 1; i <= 3; i++) send(30'(i), 4'd1, 1'b0);
        do_stop();
        check("post_state", 64'(st_w[0]), 64'd2);
        for (int i = 4; i <= 7; i++) send(30'(i), 4'd1, 1'b0);
        check("a_done", 64'(st_w[0]), 64'd3);
        check("a_entries", 64'(ent0), 64'd7);
        check("a_wrapped", 64'(wr_w[0]), 64'd0);
        dump(1'b0);

        // Wrap: 24 frames into a 16-deep store, dumped under backpressure
        do_arm();
        for (int i = 0; i < 20; i++) send(30'(i), 4'd2, 1'b0);
        do_stop();
        for (int i = 20; i < 24; i++) send(30'(i), 4'd2, 1'b0);
        check("b_done", 64'(st_w[0]), 64'd3);
        check("b_entries", 64'(ent0), 64'(exp_q.size()));
        check("b_wrapped", 64'(wr_w[0]), 64'(m_wrapped));
        dump(1'b1);

        // Stop and frame together: that frame is stored but not post-counted
        do_arm();
        send(30'h111, 4'd3, 1'b0);
        send(30'h222, 4'd3, 1'b0);
        send(30'h333, 4'd3, 1'b1);
        for (int i = 0; i < 4; i++) send(30'h400 + 30'(i), 4'd5, 1'b0);
        check("e_done", 64'(st_w[0]), 64'd3);
        check("e_entries", 64'(ent0), 64'd7);
        send(30'h3ff, 4'd7, 1'b0);
        dump(1'b1);

        // No-wrap depth 4: freezes after the fourth frame, later stop ignored
        use_inst(1);
        do_arm();
        for (int i = 0; i < 6; i++) send(30'(i), 4'd1, 1'b0);
        do_stop();
        check("c_done", 64'(st_w[1]), 64'd3);
        check("c_entries", 64'(ent_sel()), 64'd4);
        check("c_wrapped", 64'(wr_w[1]), 64'd0);
        dump(1'b0);

        // Mid-capture reset, then an empty POST_COUNT=0 session
        use_inst(0);
        do_arm();
        for (int i = 0; i < 5; i++) send(30'(i + 50), 4'd1, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst_state", 64'(st_w[0]), 64'd0);
        check("rst_entries", 64'(ent0), 64'd0);
        check("rst_rd_valid", 64'(rdv_w[0]), 64'd0);
        use_inst(2);
        do_arm();
        do_stop();
        check("d_done", 64'(st_w[2]), 64'd3);
        check("d_entries", 64'(ent2), 64'd0);
        check("d_no_valid0", 64'(rdv_w[2]), 64'd0);
        tick();
        check("d_dump_done", 64'(dd_w[2]), 64'd1);
        check("d_no_valid1", 64'(rdv_w[2]), 64'd0);
        check("d_idle", 64'(st_w[2]), 64'd0);
        tick();
        check("d_dump_done_end", 64'(dd_w[2]), 64'd0);

        // POST_COUNT=0 with a frame on the stop cycle: stored, then DONE
        do_arm();
        send(30'h0aa, 4'd4, 1'b0);
        send(30'h0bb, 4'd4, 1'b1);
        send(30'h0cc, 4'd4, 1'b0);
        check("f_done", 64'(st_w[2]), 64'd3);
        check("f_entries", 64'(ent2), 64'd2);
        dump(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
